// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding and access size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    IF_RD = 2'b01,
    LS_RD = 2'b10,
    LS_WR = 2'b11
  } state_e;

  localparam logic HALFWORD = 1'b0;
  localparam logic WORD     = 1'b1;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of LS grants taken while fetch is waiting; starve forces the next grant to IF.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ls_gnt,
  input  logic if_gnt,
  input  logic if_req_i,
  input  logic idle,
  output logic starve
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (if_gnt || (idle && !if_req_i)) begin
      cnt <= '0;
    end else if (ls_gnt && if_req_i && !starve) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starve = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (read-only) and load/store; LS priority with IF anti-starvation.
// Optional access timeout is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_done_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic              ls_word_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_done_o,
  output logic              ls_err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic              mem_word_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  input  logic              mem_wready_i
);

  state_e state, state_nxt;
  logic   if_gnt, ls_gnt, starve;
  logic   rd_cpl, wr_cpl, abort;

  // Completions only count when they match the access in flight.
  assign rd_cpl = ((state == IF_RD) || (state == LS_RD)) && mem_rvalid_i;
  assign wr_cpl = (state == LS_WR) && mem_wready_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;

  // IDLE always precedes an access, so clearing there clears on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign abort = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !rd_cpl && !wr_cpl;
`else
  assign abort = 1'b0;
`endif

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .ls_gnt  (ls_gnt),
    .if_gnt  (if_gnt),
    .if_req_i(if_req_i),
    .idle    (state == IDLE),
    .starve  (starve)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req_i && (!starve || !if_req_i)) begin
          ls_gnt    = 1'b1;
          state_nxt = ls_we_i ? LS_WR : LS_RD;
        end else if (if_req_i) begin
          if_gnt    = 1'b1;
          state_nxt = IF_RD;
        end
      end
      IF_RD, LS_RD: begin
        if (rd_cpl || abort) state_nxt = IDLE;
      end
      LS_WR: begin
        if (wr_cpl || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if_gnt_o  = if_gnt;
    ls_gnt_o  = ls_gnt;
    if_done_o = (state == IF_RD) && (rd_cpl || abort);
    ls_done_o = ((state == LS_RD) || (state == LS_WR)) && (rd_cpl || wr_cpl || abort);
    ls_err_o  = ((state == LS_RD) || (state == LS_WR)) && abort;
    rdata_o   = rd_cpl ? mem_rdata_i : '0;
    mem_re_o  = ((state == IF_RD) || (state == LS_RD)) && !abort;
    mem_we_o  = (state == LS_WR) && !abort;
  end

  // Access attributes are captured at grant and held until the access retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_word_o  <= HALFWORD;
    end else if (ls_gnt) begin
      mem_addr_o  <= ls_addr_i;
      mem_wdata_o <= ls_wdata_i;
      mem_word_o  <= ls_word_i;
    end else if (if_gnt) begin
      mem_addr_o  <= if_addr_i;
      mem_word_o  <= HALFWORD;
    end
  end

endmodule
